// File: rtl/subtractor_64_seq_if.sv
// -----------------------------------------------------------------------------
// subtractor_64_seq_if
// Handshake and data bundle for the sequential 64-bit subtractor.
//   in_valid / in_ready   : operand request / block can accept operands
//   in1, in2, bin         : minuend, subtrahend, borrow-in
//   out_valid / out_ready : result available / consumer accepts the result
//   diff, bout, zero, ovf : in1 - in2 - bin, borrow-out, zero flag, signed overflow
// master drives operands and out_ready; slave is the subtractor itself.
// -----------------------------------------------------------------------------
interface subtractor_64_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in1;
  logic [63:0] in2;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        zero;
  logic        ovf;

  modport master (
    output in_valid, in1, in2, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, in1, in2, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/subtractor_64_seq.sv
// -----------------------------------------------------------------------------
// subtractor_64_seq
// Multi-cycle 64-bit subtractor that processes SLICE_W bits per clock.
// Computes diff = in1 - in2 - bin (mod 2^64) with borrow-out, zero flag and
// signed overflow. A result appears 64/SLICE_W cycles after the operand
// accept and is held until the consumer takes it.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : subtractor_64_seq_if.slave (operand/result handshake)
//   SLICE_W : bits per cycle, one of 8, 16, 32, 64
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, waiting for in_valid; last result still visible
// BUSY  | one slice per edge, lowest slice first, borrow rippled forward
// DONE  | out_valid high, result frozen until out_ready
// -----------------------------------------------------------------------------
module subtractor_64_seq #(
  parameter int SLICE_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  subtractor_64_seq_if.slave   bus
);

  localparam int N     = 64 / SLICE_W;
  localparam int CNT_W = 4;

  if (SLICE_W != 8 && SLICE_W != 16 && SLICE_W != 32 && SLICE_W != 64) begin : g_bad_slice_w
    $error("subtractor_64_seq: SLICE_W must be 8, 16, 32 or 64");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [63:0]        a_q;
  logic [63:0]        b_q;
  logic [63:0]        work_q;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [63:0]        diff_q;
  logic               bout_q;
  logic               zero_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [SLICE_W-1:0] a_s;
  logic [SLICE_W-1:0] b_s;
  logic [SLICE_W:0]   s_res;
  logic [63:0]        work_nxt;
  logic               last;

  // Slice select by constant-index loop keeps the mux free of variable
  // part-selects.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_s = a_q[k*SLICE_W +: SLICE_W];
        b_s = b_q[k*SLICE_W +: SLICE_W];
      end
    end
  end

  // Extra MSB of the zero-extended difference is the slice borrow-out.
  assign s_res = {1'b0, a_s} - {1'b0, b_s} - {{SLICE_W{1'b0}}, borrow_q};

  always_comb begin
    work_nxt = work_q;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        work_nxt[k*SLICE_W +: SLICE_W] = s_res[SLICE_W-1:0];
      end
    end
  end

  assign last = (cnt_q == CNT_W'(N - 1));

  // work_q accumulates slices privately so the visible diff keeps the
  // previous result until the new one is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.in1;
            b_q        <= bus.in2;
            borrow_q   <= bus.bin;
            cnt_q      <= '0;
            work_q     <= '0;
            in_ready_q <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          work_q   <= work_nxt;
          borrow_q <= s_res[SLICE_W];
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last) begin
            diff_q      <= work_nxt;
            bout_q      <= s_res[SLICE_W];
            zero_q      <= (work_nxt == 64'd0);
            ovf_q       <= (a_q[63] != b_q[63]) && (work_nxt[63] != a_q[63]);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE here deliberately costs a cycle: no accept
          // can share the release edge.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_subtractor_64_seq.sv
// -----------------------------------------------------------------------------
// tb_subtractor_64_seq
// Self-checking bench for subtractor_64_seq: directed corner cases, random
// operands with random backpressure, back-to-back throughput and mid-op reset.
// -----------------------------------------------------------------------------
module tb_subtractor_64_seq;
  localparam int SLICE_W = 16;
  localparam int N       = 64 / SLICE_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;

  subtractor_64_seq_if bus();

  subtractor_64_seq #(.SLICE_W(SLICE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string what,
                       input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the operands.
  function automatic void ref_model(input logic [63:0] a, input logic [63:0] b,
                                    input logic bi, output logic [63:0] d,
                                    output logic bo, output logic z, output logic o);
    logic signed [65:0] sd;
    d  = a - b - 64'(bi);
    bo = ({1'b0, a} < ({1'b0, b} + 65'(bi)));
    z  = (d == 64'd0);
    sd = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, bi});
    // True result fits in 64-bit signed iff its top three bits agree.
    o  = (sd[65:63] != 3'b000) && (sd[65:63] != 3'b111);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Call with inputs driven away from the clock edge.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bi,
                        input int hold, input string tag);
    logic [63:0] ed;
    logic eb, ez, eo;
    int   lat;
    ref_model(a, b, bi, ed, eb, ez, eo);
    lat = 0;
    while (!bus.in_ready && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check(tag, "in_ready", 64'(bus.in_ready), 64'd1);
    bus.in1 = a; bus.in2 = b; bus.bin = bi; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.in1 = rnd64(); bus.in2 = rnd64(); bus.bin = ~bi;
      @(posedge clk); #1; lat++;
    end
    check(tag, "latency", 64'(lat), 64'(N));
    check(tag, "diff", bus.diff, ed);
    check(tag, "bout", 64'(bus.bout), 64'(eb));
    check(tag, "zero", 64'(bus.zero), 64'(ez));
    check(tag, "ovf",  64'(bus.ovf),  64'(eo));
    for (int i = 0; i < hold; i++) begin
      bus.in1 = rnd64(); bus.in2 = rnd64(); bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check(tag, "hold_diff", bus.diff, ed);
      check(tag, "hold_flags", {61'd0, bus.bout, bus.zero, bus.ovf}, {61'd0, eb, ez, eo});
      check(tag, "hold_hs", {62'd0, bus.out_valid, bus.in_ready}, 64'b10);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check(tag, "release_hs", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    check(tag, "retain_diff", bus.diff, ed);
  endtask

  initial begin
    logic [63:0] ra, rb, ed;
    logic        rbi, eb, ez, eo;
    int          seen[$];
    int          cyc;
    bit          any_valid;

    bus.in_valid = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.bin = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "diff", bus.diff, 64'd0);
    check("reset", "flags", {61'd0, bus.bout, bus.zero, bus.ovf}, 64'd0);
    check("reset", "hs", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);

    // First accept on the first edge after release.
    @(negedge clk); rst_n = 1'b1;
    run_op(64'd5, 64'd3, 1'b0, 0, "five_minus_three");
    run_op(64'd0, 64'd1, 1'b0, 1, "zero_minus_one");
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 0, "signed_ovf");
    run_op(64'h1234, 64'h1234, 1'b0, 0, "equal_zero");
    run_op(64'h1234, 64'h1234, 1'b1, 0, "equal_bin");
    run_op(64'h0000_0001_0000_0000, 64'd1, 1'b0, 0, "ripple");
    run_op(64'h8000_0000_0000_0000, 64'd0, 1'b1, 0, "ovf_by_bin");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, "ones_bin");
    run_op(64'hDEAD_BEEF_0000_0000, 64'h0123_4567_89AB_CDEF, 1'b0, 5, "backpressure");

    for (int t = 0; t < 24; t++) begin
      ra  = rnd64();
      rb  = ($urandom_range(0, 5) == 0) ? ra : rnd64();
      rbi = 1'($urandom_range(0, 1));
      run_op(ra, rb, rbi, int'($urandom_range(0, 3)), "random");
    end

    // Back-to-back with in_valid and out_ready held high.
    ref_model(64'd1000, 64'd1, 1'b0, ed, eb, ez, eo);
    bus.in1 = 64'd1000; bus.in2 = 64'd1; bus.bin = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (cyc = 0; cyc < 4 * (N + 2); cyc++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        seen.push_back(cyc);
        check("b2b", "diff", bus.diff, ed);
        @(posedge clk); #1; cyc++;
        check("b2b", "idle_after_done", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
        @(posedge clk); #1; cyc++;
        check("b2b", "accept_next", {62'd0, bus.out_valid, bus.in_ready}, 64'b00);
      end
    end
    check("b2b", "results", 64'(seen.size() >= 3), 64'd1);
    for (int i = 1; i < seen.size(); i++)
      check("b2b", "period", 64'(seen[i] - seen[i-1]), 64'(N + 2));
    bus.in_valid = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("b2b", "drained", 64'(bus.in_ready), 64'd1);

    // Reset in the middle of BUSY; the previous result is nonzero.
    run_op(64'd5, 64'd3, 1'b0, 0, "pre_reset");
    bus.in1 = 64'd100; bus.in2 = 64'd1; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", "diff", bus.diff, 64'd0);
    check("mid_reset", "flags", {61'd0, bus.bout, bus.zero, bus.ovf}, 64'd0);
    check("mid_reset", "hs", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    @(negedge clk); rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (3 * N) begin
      @(posedge clk); #1;
      if (bus.out_valid) any_valid = 1'b1;
    end
    check("mid_reset", "no_valid", 64'(any_valid), 64'd0);
    run_op(64'd9, 64'd4, 1'b0, 0, "after_reset");
    check("after_reset", "diff_five", bus.diff, 64'd5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
